// File: rtl/pc_fetch_gen.sv
// pc_fetch_gen -- program-counter generator for the head of the IF stage.
//
// Holds the current PC and issues a fetch request to instruction memory.
// The PC advances only when a request is accepted (RUN state, ack high,
// stall[0] low). Branches that arrive while the PC cannot advance are
// latched as a pending redirect and applied on the next accepted fetch.
// CP0 redirects (exceptions / ERET) win over everything and pass through a
// one-cycle FLUSH state with the request dropped.
//
// Build option (macro PC_MISALIGN_TRAP_EN):
//   defined   - redirect targets are loaded unchanged. A misaligned PC
//               raises adel_o, captures badaddr_o and blocks fetch_req_o
//               until a cp0 redirect or reset.
//   undefined - redirect targets are force-aligned to INST_BYTES, and
//               adel_o / badaddr_o are tied to 0.
//
// Parameters:
//   ADDR_W     PC / address width
//   RESET_VEC  PC loaded on reset
//   INST_BYTES sequential increment (power of two)
//   STALL_W    stall vector width (only bit 0 is used)
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   stall               stall vector, bit 0 freezes PC advance
//   branch_flag_i/target_i  branch redirect request and target
//   cp0_flag_i/addr_i   exception / ERET redirect and target
//   fetch_ack_i         instruction memory accepted the request
//   fetch_req_o         fetch request valid
//   fetch_addr_o        fetch address (same as pc_o)
//   pc_o                current PC
//   pc_valid_o          pulse in the cycle after an accepted fetch
//   redirect_pending_o  a branch redirect is latched, not yet applied
//   adel_o, badaddr_o   misaligned fetch exception and offending address
module pc_fetch_gen #(
  parameter int unsigned        ADDR_W     = 32,
  parameter logic [ADDR_W-1:0]  RESET_VEC  = ADDR_W'(32'hBFC00000),
  parameter int unsigned        INST_BYTES = 4,
  parameter int unsigned        STALL_W    = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               branch_flag_i,
  input  logic [ADDR_W-1:0]  branch_target_i,
  input  logic               cp0_flag_i,
  input  logic [ADDR_W-1:0]  cp0_addr_i,
  input  logic               fetch_ack_i,
  output logic               fetch_req_o,
  output logic [ADDR_W-1:0]  fetch_addr_o,
  output logic [ADDR_W-1:0]  pc_o,
  output logic               pc_valid_o,
  output logic               redirect_pending_o,
  output logic               adel_o,
  output logic [ADDR_W-1:0]  badaddr_o
);

  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  // Byte-offset bits within one instruction, and the sequential step.
  localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(INST_BYTES - 1);
  localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(INST_BYTES);

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_pc;
  logic              r_pend_vld;
  logic [ADDR_W-1:0] r_pend_tgt;
  logic              r_pc_valid;

  logic [ADDR_W-1:0] w_br_tgt;
  logic [ADDR_W-1:0] w_cp0_tgt;
  logic              w_misaligned;
  logic              w_req;
  logic              w_advance;

  logic [1:0]        w_state_nxt;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic              w_pc_redirect;
  logic              w_pend_vld_nxt;
  logic [ADDR_W-1:0] w_pend_tgt_nxt;
  logic              w_pc_valid_nxt;

  // Only stall[0] matters to this stage; the rest of the vector is ignored.
  logic              w_stall_unused;
  assign w_stall_unused = ^stall;

`ifdef PC_MISALIGN_TRAP_EN
  assign w_br_tgt     = branch_target_i;
  assign w_cp0_tgt    = cp0_addr_i;
  assign w_misaligned = |(r_pc & LOW_MASK);
`else
  assign w_br_tgt     = branch_target_i & ~LOW_MASK;
  assign w_cp0_tgt    = cp0_addr_i & ~LOW_MASK;
  assign w_misaligned = 1'b0;
`endif

  assign w_req     = (r_state == S_RUN) && !w_misaligned;
  assign w_advance = w_req && fetch_ack_i && !stall[0];

  // Redirect priority: cp0 > pending branch > new branch > sequential.
  // A branch that cannot be taken this cycle (no advance, or the pending
  // slot is being consumed) goes into the pending slot, newest wins.
  always_comb begin
    w_state_nxt    = S_RUN;
    w_pc_nxt       = r_pc;
    w_pc_redirect  = 1'b0;
    w_pend_vld_nxt = r_pend_vld;
    w_pend_tgt_nxt = r_pend_tgt;
    w_pc_valid_nxt = 1'b0;

    if (cp0_flag_i) begin
      w_state_nxt    = S_FLUSH;
      w_pc_nxt       = w_cp0_tgt;
      w_pc_redirect  = 1'b1;
      w_pend_vld_nxt = 1'b0;
    end else if (w_advance && r_pend_vld) begin
      w_pc_nxt       = r_pend_tgt;
      w_pc_redirect  = 1'b1;
      w_pc_valid_nxt = 1'b1;
      w_pend_vld_nxt = branch_flag_i;
      if (branch_flag_i) begin
        w_pend_tgt_nxt = w_br_tgt;
      end
    end else if (w_advance && branch_flag_i) begin
      w_pc_nxt       = w_br_tgt;
      w_pc_redirect  = 1'b1;
      w_pc_valid_nxt = 1'b1;
    end else if (w_advance) begin
      w_pc_nxt       = r_pc + STEP;
      w_pc_valid_nxt = 1'b1;
    end else if (branch_flag_i) begin
      w_pend_vld_nxt = 1'b1;
      w_pend_tgt_nxt = w_br_tgt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_BOOT;
      r_pc       <= RESET_VEC;
      r_pend_vld <= 1'b0;
      r_pend_tgt <= '0;
      r_pc_valid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_pend_vld <= w_pend_vld_nxt;
      r_pend_tgt <= w_pend_tgt_nxt;
      r_pc_valid <= w_pc_valid_nxt;
    end
  end

`ifdef PC_MISALIGN_TRAP_EN
  logic [ADDR_W-1:0] r_badaddr;

  // Sequential steps keep alignment, so only a redirect can misalign the PC.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_badaddr <= '0;
    end else if (w_pc_redirect && |(w_pc_nxt & LOW_MASK)) begin
      r_badaddr <= w_pc_nxt;
    end
  end

  assign adel_o    = w_misaligned;
  assign badaddr_o = r_badaddr;
`else
  logic w_redirect_unused;
  assign w_redirect_unused = w_pc_redirect;

  assign adel_o    = 1'b0;
  assign badaddr_o = '0;
`endif

  assign fetch_req_o        = w_req;
  assign fetch_addr_o       = r_pc;
  assign pc_o               = r_pc;
  assign pc_valid_o         = r_pc_valid;
  assign redirect_pending_o = r_pend_vld;

endmodule

// File: tb/tb_pc_fetch_gen.sv
// Testbench for pc_fetch_gen: directed scenarios followed by random
// stimulus, checked against a behavioural model through two scoreboards.
module tb_pc_fetch_gen;

  localparam int unsigned       AW = 32;
  localparam logic [31:0]       RV = 32'hBFC00000;
  localparam int unsigned       IB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        cp0_flag_i;
  logic [31:0] cp0_addr_i;
  logic        fetch_ack_i;
  logic        fetch_req_o;
  logic [31:0] fetch_addr_o;
  logic [31:0] pc_o;
  logic        pc_valid_o;
  logic        redirect_pending_o;
  logic        adel_o;
  logic [31:0] badaddr_o;

  always #5 clk = ~clk;

  pc_fetch_gen #(
    .ADDR_W(AW),
    .RESET_VEC(RV),
    .INST_BYTES(IB),
    .STALL_W(6)
  ) dut (
    .clk(clk),
    .rst(rst),
    .stall(stall),
    .branch_flag_i(branch_flag_i),
    .branch_target_i(branch_target_i),
    .cp0_flag_i(cp0_flag_i),
    .cp0_addr_i(cp0_addr_i),
    .fetch_ack_i(fetch_ack_i),
    .fetch_req_o(fetch_req_o),
    .fetch_addr_o(fetch_addr_o),
    .pc_o(pc_o),
    .pc_valid_o(pc_valid_o),
    .redirect_pending_o(redirect_pending_o),
    .adel_o(adel_o),
    .badaddr_o(badaddr_o)
  );

  typedef struct {
    logic [31:0] pc;
    logic        req;
    logic        valid;
    logic        pend;
    logic        adel;
    logic [31:0] bad;
  } status_t;

  status_t     exp_q[$];
  logic [31:0] fetch_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_pc;
  logic [31:0] m_bad;
  logic [31:0] m_pend[$];   // at most one latched redirect
  int          m_hold;      // cycles left with the request suppressed
  logic        m_valid;

  function automatic logic mis(input logic [31:0] a);
`ifdef PC_MISALIGN_TRAP_EN
    return (a % 32'(IB)) != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] fix(input logic [31:0] a);
`ifdef PC_MISALIGN_TRAP_EN
    return a;
`else
    return a - (a % 32'(IB));
`endif
  endfunction

  function automatic logic m_req();
    return (m_hold == 0) && !mis(m_pc);
  endfunction

  task automatic load(input logic [31:0] a);
    m_pc = a;
    if (mis(a)) m_bad = a;
  endtask

  // One clock: drive inputs, predict, then record the expected status.
  task automatic step(input logic r, input logic s, input logic b, input logic [31:0] bt,
                      input logic c, input logic [31:0] ca, input logic ack);
    logic acc;
    rst             = r;
    stall           = {5'($urandom), s};
    branch_flag_i   = b;
    branch_target_i = bt;
    cp0_flag_i      = c;
    cp0_addr_i      = ca;
    fetch_ack_i     = ack;
    if (r) begin
      m_pc = RV; m_bad = '0; m_pend.delete(); m_hold = 1; m_valid = 1'b0;
    end else begin
      acc = m_req() && ack && !s;
      if (c) begin
        load(fix(ca)); m_pend.delete(); m_hold = 1; m_valid = 1'b0;
      end else if (acc) begin
        m_valid = 1'b1;
        if (m_pend.size() > 0) begin
          load(m_pend.pop_front());
          if (b) m_pend.push_back(fix(bt));
        end else if (b) begin
          load(fix(bt));
        end else begin
          m_pc = m_pc + 32'(IB);
        end
      end else begin
        m_valid = 1'b0;
        if (m_hold > 0) m_hold--;
        if (b) begin
          m_pend.delete();
          m_pend.push_back(fix(bt));
        end
      end
    end
    if (m_valid) fetch_q.push_back(m_pc);
    @(posedge clk);
    #1;
    exp_q.push_back('{m_pc, m_req(), m_valid, m_pend.size() != 0, mis(m_pc), m_bad});
  endtask

  task automatic idle(input logic ack);
    step(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, ack);
  endtask

  // ---------------- monitor ----------------
  status_t e;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("pc_o",               pc_o,                      e.pc);
      chk("fetch_addr_o",       fetch_addr_o,              e.pc);
      chk("fetch_req_o",        32'(fetch_req_o),          32'(e.req));
      chk("pc_valid_o",         32'(pc_valid_o),           32'(e.valid));
      chk("redirect_pending_o", 32'(redirect_pending_o),   32'(e.pend));
      chk("adel_o",             32'(adel_o),               32'(e.adel));
      chk("badaddr_o",          badaddr_o,                 e.bad);
    end
    if (pc_valid_o === 1'b1) begin
      if (fetch_q.size() > 0) begin
        chk("fetch_pc", pc_o, fetch_q.pop_front());
      end else begin
        n_checks++;
        $display("FAIL fetch_unexpected: pc_valid_o=1 with pc_o=%h, expected no accepted fetch", pc_o);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    logic r, s, b, c, ack;
    logic [31:0] bt, ca;

    // Reset for two cycles, then sequential fetches.
    step(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
    repeat (4) idle(1'b1);

    // Stalled branch: latched, applied after release.
    step(1'b0, 1'b1, 1'b1, 32'h80000100, 1'b0, '0, 1'b1);
    step(1'b0, 1'b1, 1'b0, '0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b1, 1'b0, '0, 1'b0, '0, 1'b1);
    repeat (3) idle(1'b1);

    // cp0 beats a new branch and a pending one.
    step(1'b0, 1'b1, 1'b1, 32'h80000040, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 32'h80000040, 1'b1, 32'h80000180, 1'b1);
    repeat (3) idle(1'b1);

    // Wrap-around, then ack wait.
    step(1'b0, 1'b0, 1'b1, 32'hFFFFFFF8, 1'b0, '0, 1'b1);
    repeat (3) idle(1'b1);
    repeat (4) idle(1'b0);
    repeat (2) idle(1'b1);

    // Misaligned branch target, then cp0 recovery.
    step(1'b0, 1'b0, 1'b1, 32'h80000102, 1'b0, '0, 1'b1);
    repeat (2) idle(1'b1);
    step(1'b0, 1'b0, 1'b0, '0, 1'b1, 32'h80000000, 1'b1);
    repeat (3) idle(1'b1);

    // Reset while stalled with a redirect pending.
    step(1'b0, 1'b1, 1'b1, 32'h12345678, 1'b0, '0, 1'b1);
    step(1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 1'b1);
    repeat (3) idle(1'b1);

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      r   = ($urandom % 100) < 1;
      s   = ($urandom % 100) < 25;
      b   = ($urandom % 100) < 15;
      c   = ($urandom % 100) < 3;
      ack = ($urandom % 100) < 70;
      bt  = $urandom;
      ca  = $urandom;
      if (($urandom % 4) != 0) bt = bt & 32'hFFFFFFFC;
      if (($urandom % 4) != 0) ca = ca & 32'hFFFFFFFC;
      step(r, s, b, bt, c, ca, ack);
    end

    repeat (2) idle(1'b0);
    @(negedge clk);
    #1;
    chk("fetch_q_drained",  32'(fetch_q.size()), 32'd0);
    chk("status_q_drained", 32'(exp_q.size()),   32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
